fdivsqrt_iter_ctrl: RTL and testbench

- Controller that sequences the radix-4 divide/square-root digit recurrence: the digit-selection, F-addend-generation and residual-update stages that consume one quotient digit per cycle.
- Accepts an operation over a valid/ready handshake, issues the init and per-iteration enables, and counts iterations.
- Handles special-case bypass, flush and optional early termination.
- Holds the result-valid indication until the downstream stage acknowledges it.

---
 rtl/fdivsqrt_iter_ctrl.sv | 118 +++++++++++
 tb/tb_fdivsqrt_iter_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration controller for the radix-4 divide/sqrt recurrence: accept, per-step enables, done hold.
// Optional early termination on a zero residual is enabled by defining FDIVSQRT_EARLY_TERM_EN.
module fdivsqrt_iter_ctrl #(
  parameter int CNTW    = 6,
  parameter int MAXITER = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Start,
  output logic            Ready,
  input  logic            SqrtE,
  input  logic [CNTW-1:0] NumIter,
  input  logic            SpecialCase,
  input  logic            Flush,
  input  logic            ResZero,
  input  logic            ResultAck,
  output logic            InitE,
  output logic            IterEn,
  output logic            SqrtM,
  output logic            Busy,
  output logic            Done,
  output logic [CNTW-1:0] IterCount
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNTW-1:0] MAX_N = CNTW'(MAXITER);
  localparam logic [CNTW-1:0] ONE   = CNTW'(1);

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            sqrtm_q, sqrtm_d;
  logic            accept;
  logic            term;
  logic [CNTW-1:0] n_eff;

  assign Ready     = ~Flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & ResultAck));
  assign accept    = Start & Ready;
  // Ready idles high during reset, so gate InitE to keep the datapath quiet until release.
  assign InitE     = accept & reset_n;
  assign IterEn    = (state_q == S_ITER) & ~Flush;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign SqrtM     = sqrtm_q;
  assign IterCount = cnt_q;

  always_comb begin
    if (NumIter > MAX_N) begin
      n_eff = MAX_N;
    end else if (NumIter == '0) begin
      n_eff = ONE;
    end else begin
      n_eff = NumIter;
    end
  end

`ifdef FDIVSQRT_EARLY_TERM_EN
  assign term = (rem_q == '0) | ResZero;
`else
  logic unused_reszero;
  assign unused_reszero = ResZero;
  assign term = (rem_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sqrtm_d = sqrtm_q;
    if (Flush) begin
      state_d = S_IDLE;
      rem_d   = '0;
    end else if (accept) begin
      state_d = SpecialCase ? S_DONE : S_ITER;
      rem_d   = n_eff - ONE;
      cnt_d   = '0;
      sqrtm_d = SqrtE;
    end else begin
      case (state_q)
        S_ITER: begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + ONE;
          end
          if (term) begin
            state_d = S_DONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - ONE;
          end
        end
        S_DONE: begin
          if (ResultAck) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      sqrtm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sqrtm_q <= sqrtm_d;
    end
  end

endmodule

// File: tb/tb_fdivsqrt_iter_ctrl.sv
// Scoreboard bench for fdivsqrt_iter_ctrl: stimulus pushes expected op outcomes, a monitor checks them.
module tb_fdivsqrt_iter_ctrl;
  localparam int MAXN = 32;

  logic       clk;
  logic       reset_n;
  logic       Start, Ready, SqrtE, SpecialCase, Flush, ResZero, ResultAck;
  logic [5:0] NumIter;
  logic       InitE, IterEn, SqrtM, Busy, Done;
  logic [5:0] IterCount;

  fdivsqrt_iter_ctrl #(.CNTW(6), .MAXITER(MAXN)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Ready(Ready), .SqrtE(SqrtE),
    .NumIter(NumIter), .SpecialCase(SpecialCase), .Flush(Flush), .ResZero(ResZero),
    .ResultAck(ResultAck), .InitE(InitE), .IterEn(IterEn), .SqrtM(SqrtM), .Busy(Busy),
    .Done(Done), .IterCount(IterCount)
  );

  always #5 clk = ~clk;

  // kind: 0 = completes normally, 1 = flushed, 2 = aborted by reset
  typedef struct {
    int iters;
    int lat;
    int cnt;
    bit sqm;
    int kind;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  bit   act = 0;
  bit   got_done = 0;
  int   age = 0;
  int   iters = 0;
  bit   done_pend = 0;

  task automatic chk(input string nm, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, actual, required, $time);
    end
  endtask

  task automatic close_out();
    if (act && cur.kind == 0) chk("missing_done", int'(got_done), 1);
    if (act && cur.kind == 1) chk("flush_iter_cycles", iters, cur.iters);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      act = 0;
      got_done = 0;
    end else begin
      if (act) age++;
      if (IterEn) begin
        if (!act) chk("spurious_iteren", int'(IterEn), 0);
        else iters++;
      end
      if (Done) begin
        if (!act || cur.kind != 0) chk("spurious_done", int'(Done), 0);
        else if (!got_done) begin
          got_done = 1;
          chk("done_latency", age, cur.lat);
          chk("iter_cycles", iters, cur.iters);
          chk("itercount", int'(IterCount), cur.cnt);
          chk("sqrtm", int'(SqrtM), int'(cur.sqm));
        end
      end
      if (InitE) begin
        close_out();
        if (exp_q.size() == 0) chk("unexpected_accept", int'(InitE), 0);
        else begin
          cur = exp_q.pop_front();
          act = 1;
          got_done = 0;
          age = 0;
          iters = 0;
        end
      end
    end
  end

  task automatic ack_only();
    ResultAck = 1;
    @(posedge clk); #1;
    ResultAck = 0;
    done_pend = 0;
    @(negedge clk);
    chk("ack_ready", int'(Ready), 1);
    chk("ack_busy", int'(Busy), 0);
    chk("ack_done", int'(Done), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input bit sq, input logic [5:0] ni, input bit sp, input int fl_at,
                        input int rz_at, input int hold, input bit b2b);
    exp_t e;
    int   n;
    int   it;
    bit   fin;
    if (done_pend && !b2b) ack_only();
    n  = (int'(ni) > MAXN) ? MAXN : ((ni == 0) ? 1 : int'(ni));
    it = sp ? 0 : n;
`ifdef FDIVSQRT_EARLY_TERM_EN
    if (!sp && rz_at >= 1 && rz_at <= it) it = rz_at;
`endif
    e.sqm = sq;
    if (fl_at > 0) begin
      e.kind = 1; e.iters = fl_at - 1; e.cnt = fl_at - 1; e.lat = 0;
    end else begin
      e.kind = 0; e.iters = it; e.cnt = it; e.lat = sp ? 1 : it + 1;
    end
    exp_q.push_back(e);
    Start = 1; SqrtE = sq; NumIter = ni; SpecialCase = sp; ResultAck = done_pend;
    @(negedge clk);
    chk("ready_at_start", int'(Ready), 1);
    @(posedge clk); #1;
    Start = 0; ResultAck = 0; SqrtE = ~sq; NumIter = 6'($urandom); SpecialCase = 1'($urandom);
    done_pend = 0;
    fin = 0;
    for (int c = 1; c <= 80 && !fin; c++) begin
      ResZero = (c == rz_at);
      Flush   = (c == fl_at);
      Start   = (c == fl_at) || (c == 2);
      @(negedge clk);
      if (c == 1) begin
        chk("busy_in_op", int'(Busy), 1);
        chk("ready_in_op", int'(Ready), 0);
      end
      if (Done) begin
        fin = 1;
        done_pend = 1;
      end
      @(posedge clk); #1;
      if (c == fl_at) begin
        fin = 1;
        Flush = 0; Start = 0; ResZero = 0;
        @(negedge clk);
        chk("flush_busy", int'(Busy), 0);
        chk("flush_done", int'(Done), 0);
        chk("flush_itercount", int'(IterCount), fl_at - 1);
        @(posedge clk); #1;
      end
    end
    Start = 0; Flush = 0; ResZero = 0;
    if (!fin) chk("op_timeout", 0, 1);
    for (int h = 0; h < hold && done_pend; h++) begin
      @(negedge clk);
      chk("done_held", int'(Done), 1);
      chk("hold_itercount", int'(IterCount), e.cnt);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid_op();
    exp_t e;
    if (done_pend) ack_only();
    e.iters = 0; e.lat = 0; e.cnt = 0; e.sqm = 1; e.kind = 2;
    exp_q.push_back(e);
    Start = 1; SqrtE = 1; NumIter = 6'd20; SpecialCase = 0;
    @(posedge clk); #1;
    Start = 0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 0;
    #1;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_iteren", int'(IterEn), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_itercount", int'(IterCount), 0);
    chk("rst_sqrtm", int'(SqrtM), 0);
    chk("rst_ready", int'(Ready), 1);
    @(posedge clk); #1;
    reset_n = 1;
    done_pend = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit         sq, sp, b2b;
    logic [5:0] ni;
    int         n, fl, rz, hold;
    clk = 0; reset_n = 0; Start = 0; SqrtE = 0; NumIter = 0; SpecialCase = 0;
    Flush = 0; ResZero = 0; ResultAck = 0;
    #12;
    chk("reset_ready", int'(Ready), 1);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_iteren", int'(IterEn), 0);
    chk("reset_itercount", int'(IterCount), 0);
    chk("reset_sqrtm", int'(SqrtM), 0);
    Start = 1;
    #1;
    chk("reset_inite", int'(InitE), 0);
    Start = 0;
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;

    run_op(0, 6'd14, 0, 0, 0, 1, 0);
    run_op(0, 6'd29, 1, 0, 0, 1, 0);
    run_op(0, 6'd10, 0, 0, 0, 3, 0);
    run_op(1, 6'd7,  0, 0, 0, 0, 1);
    run_op(0, 6'd14, 0, 5, 0, 0, 0);
    run_op(1, 6'd0,  0, 0, 0, 0, 0);
    run_op(0, 6'd40, 0, 0, 0, 1, 1);
    run_op(0, 6'd14, 0, 0, 4, 0, 0);
    reset_mid_op();
    for (int k = 0; k < 25; k++) begin
      sq   = 1'($urandom);
      ni   = 6'($urandom_range(0, 45));
      sp   = ($urandom_range(0, 7) == 0);
      n    = (int'(ni) > MAXN) ? MAXN : ((ni == 0) ? 1 : int'(ni));
      fl   = 0;
      rz   = 0;
      if (!sp && $urandom_range(0, 5) == 0) fl = $urandom_range(1, n);
      else if ($urandom_range(0, 2) == 0) rz = $urandom_range(1, 20);
      hold = $urandom_range(0, 3);
      b2b  = 1'($urandom);
      run_op(sq, ni, sp, fl, rz, hold, b2b);
    end
    if (done_pend) ack_only();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("last_done", (act && cur.kind == 0) ? int'(got_done) : 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
